// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcode enum, command record and default data width.
package alu_pkg;

  localparam int ALU_DW = 8;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    SHL = 3'b010,
    SHR = 3'b011,
    AND = 3'b100,
    OR  = 3'b101,
    XOR = 3'b110,
    EQ  = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers; head reads as all zeros while empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_cmd_t
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage is not reset: only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Command FIFO feeding a combinational ALU, with a registered result slot and issue counter.
// Optional result flags (res_zero_o, res_cmp_o) are enabled by defining ALU_ISSUE_FLAGS_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = ALU_DW,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [2:0]      cmd_op_i,
  input  logic [DW-1:0]   cmd_a_i,
  input  logic [DW-1:0]   cmd_b_i,
  output logic [2:0]      alu_op_o,
  output logic [DW-1:0]   alu_a_o,
  output logic [DW-1:0]   alu_b_o,
  input  logic [DW-1:0]   alu_res_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [DW-1:0]   res_data_o,
  output logic [2:0]      res_op_o,
  output logic [CNTW-1:0] issued_cnt_o,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic            res_zero_o,
  output logic            res_cmp_o,
`endif
  output logic            busy_o
);

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_t;

  cmd_t in_cmd;
  cmd_t head;
  logic full;
  logic empty;
  logic push;
  logic slot_free;
  logic issue;

  assign in_cmd    = '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i};
  assign cmd_ready_o = !full;
  assign push      = cmd_valid_i && !full;
  assign slot_free = !res_valid_o || res_ready_i;
  assign issue     = !empty && slot_free;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (issue),
    .wdata   (in_cmd),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  assign alu_op_o = head.op;
  assign alu_a_o  = head.a;
  assign alu_b_o  = head.b;
  assign busy_o   = !empty || res_valid_o;

  // An issue both refills the slot and retires any result being handed off this cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_valid_o  <= 1'b0;
      res_data_o   <= '0;
      res_op_o     <= '0;
      issued_cnt_o <= '0;
    end else if (issue) begin
      res_valid_o  <= 1'b1;
      res_data_o   <= alu_res_i;
      res_op_o     <= head.op;
      issued_cnt_o <= issued_cnt_o + CNTW'(1);
    end else if (res_valid_o && res_ready_i) begin
      res_valid_o  <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_zero_o <= 1'b0;
      res_cmp_o  <= 1'b0;
    end else if (issue) begin
      res_zero_o <= (alu_res_i == '0);
      res_cmp_o  <= (head.op == 3'(EQ)) && alu_res_i[0];
    end
  end
`endif

endmodule
